// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, sequencer states,
// instruction field positions and opcode classification helpers.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int RSEL_W  = 3;
  localparam int ALUOP_W = 5;
  localparam int IMM_W   = 8;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int AOP_LSB  = 11;
  localparam int SELD_MSB = 10;
  localparam int SELD_LSB = 8;
  localparam int SELA_MSB = 7;
  localparam int SELA_LSB = 5;
  localparam int SELB_MSB = 4;
  localparam int SELB_LSB = 2;
  localparam int IMM_MSB  = 7;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_JMPA = 4'd12;
  localparam logic [3:0] OP_JMPR = 4'd13;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_REGREAD = 3'd2,
    ST_ALU     = 3'd3,
    ST_WB      = 3'd4
  } state_e;

  function automatic logic op_writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT,
      OP_LOAD, OP_CMP, OP_SHL, OP_SHR: op_writes_reg = 1'b1;
      default:                         op_writes_reg = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT,
      OP_LOAD, OP_CMP, OP_SHL, OP_SHR, OP_JMPA, OP_JMPR: op_is_illegal = 1'b0;
      default:                                          op_is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_seq.sv
// Five-state instruction sequencer with one-hot stage enables.
module ctrl_seq
  import risc_pkg::*;
(
  input  logic       I_clk,
  input  logic       I_rstn,
  input  logic       I_stall,
  output logic [2:0] O_state,
  output logic       O_en_fetch,
  output logic       O_en_decode,
  output logic       O_en_regread,
  output logic       O_en_alu,
  output logic       O_en_wb
);

  state_e state_q, state_d;

  always_ff @(posedge I_clk) begin
    if (!I_rstn) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  // Stall only matters while waiting on instruction memory.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:   state_d = I_stall ? ST_FETCH : ST_DECODE;
      ST_DECODE:  state_d = ST_REGREAD;
      ST_REGREAD: state_d = ST_ALU;
      ST_ALU:     state_d = ST_WB;
      ST_WB:      state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    O_en_fetch   = 1'b0;
    O_en_decode  = 1'b0;
    O_en_regread = 1'b0;
    O_en_alu     = 1'b0;
    O_en_wb      = 1'b0;
    case (state_q)
      ST_FETCH:   O_en_fetch   = 1'b1;
      ST_DECODE:  O_en_decode  = 1'b1;
      ST_REGREAD: O_en_regread = 1'b1;
      ST_ALU:     O_en_alu     = 1'b1;
      ST_WB:      O_en_wb      = 1'b1;
      default:    ;
    endcase
  end

  assign O_state = state_q;

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: latches instruction fields at the end of DECODE and
// classifies the opcode; sequencing is delegated to ctrl_seq.
module decode_ctrl
  import risc_pkg::*;
(
  input  logic                I_clk,
  input  logic                I_rstn,
  input  logic                I_stall,
  input  logic [INSTR_W-1:0]  I_instr,
  output logic [ALUOP_W-1:0]  O_aluop,
  output logic [RSEL_W-1:0]   O_selD,
  output logic [RSEL_W-1:0]   O_selA,
  output logic [RSEL_W-1:0]   O_selB,
  output logic [IMM_W-1:0]    O_imm,
  output logic                O_regDwe,
  output logic                O_illegal,
  output logic [2:0]          O_state,
  output logic                O_en_fetch,
  output logic                O_en_decode,
  output logic                O_en_regread,
  output logic                O_en_alu,
  output logic                O_en_wb
);

  logic [ALUOP_W-1:0] aluop_q;
  logic [RSEL_W-1:0]  selD_q, selA_q, selB_q;
  logic [IMM_W-1:0]   imm_q;
  logic               regDwe_q, illegal_q;
  logic [3:0]         op;

  ctrl_seq u_seq (
    .I_clk        (I_clk),
    .I_rstn       (I_rstn),
    .I_stall      (I_stall),
    .O_state      (O_state),
    .O_en_fetch   (O_en_fetch),
    .O_en_decode  (O_en_decode),
    .O_en_regread (O_en_regread),
    .O_en_alu     (O_en_alu),
    .O_en_wb      (O_en_wb)
  );

  assign op = I_instr[OP_MSB:OP_LSB];

  // Fields are held from the end of DECODE until the next DECODE, giving
  // the ALU a full cycle of settled operands before its enable rises.
  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      aluop_q   <= '0;
      selD_q    <= '0;
      selA_q    <= '0;
      selB_q    <= '0;
      imm_q     <= '0;
      regDwe_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (O_en_decode) begin
      aluop_q   <= I_instr[OP_MSB:AOP_LSB];
      selD_q    <= I_instr[SELD_MSB:SELD_LSB];
      selA_q    <= I_instr[SELA_MSB:SELA_LSB];
      selB_q    <= I_instr[SELB_MSB:SELB_LSB];
      imm_q     <= I_instr[IMM_MSB:0];
      regDwe_q  <= op_writes_reg(op);
      illegal_q <= op_is_illegal(op);
    end
  end

  assign O_aluop   = aluop_q;
  assign O_selD    = selD_q;
  assign O_selA    = selA_q;
  assign O_selB    = selB_q;
  assign O_imm     = imm_q;
  assign O_regDwe  = regDwe_q;
  assign O_illegal = illegal_q;

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
Instruction decode and control-sequencing stage that sits directly upstream of the ALU in the 16-bit RISC core. It latches the fetched 16-bit instruction and splits it into the 5-bit ALU op, register selects and 8-bit immediate. A five-state sequencer (FETCH, DECODE, REGREAD, ALU, WB) produces one-hot stage enables; the ALU enable is driven from this block.

Parameters:
INSTR_W, 16, instruction width in bits
RSEL_W, 3, register-select width (8-entry register file)

Ports:
I_clk  input  1  clock; all state updates on posedge
I_rstn  input  1  synchronous reset, active-low
I_stall  input  1  instruction memory not ready; holds the sequencer in FETCH
I_instr  input  16  instruction word from fetch; valid while in DECODE
O_aluop  output  5  [4:1] opcode, [0] signed/high/register-select flag; feeds ALU I_aluop
O_selD  output  3  destination register
O_selA  output  3  source A register
O_selB  output  3  source B register
O_imm  output  8  immediate; feeds ALU I_imm
O_regDwe  output  1  register write-back enable for this instruction
O_illegal  output  1  decoded opcode is unimplemented
O_state  output  3  current sequencer state encoding
O_en_fetch  output  1  high in FETCH
O_en_decode  output  1  high in DECODE
O_en_regread  output  1  high in REGREAD
O_en_alu  output  1  high in ALU; drives ALU I_en
O_en_wb  output  1  high in WB

Behaviour:
- Reset is synchronous and active-low on I_rstn, sampled at posedge I_clk. On reset: state = FETCH (3'd0), and O_aluop, O_selD, O_selA, O_selB, O_imm, O_regDwe and O_illegal all = 0.
- Reset mid-instruction: on the next edge the sequencer returns to FETCH and all decode registers clear. No WB strobe is issued for the aborted instruction.
- State encoding: FETCH=0, DECODE=1, REGREAD=2, ALU=3, WB=4. Codes 5-7 go to FETCH on the next edge.
- Transitions:
  - FETCH to DECODE when I_stall=0; FETCH holds while I_stall=1.
  - DECODE to REGREAD, REGREAD to ALU, ALU to WB, WB to FETCH, unconditionally, 1 cycle each.
  - I_stall is ignored outside FETCH.
  - Unstalled throughput is 5 cycles per instruction.
- Enables are a combinational one-hot decode of the registered state. Exactly one enable is high at any time, and all are 0 only for the illegal codes 5-7.
- Decode fields are captured at the posedge that ends DECODE and are held stable through REGREAD, ALU and WB until the next DECODE:
  - aluop = I_instr[15:11]
  - selD = I_instr[10:8]
  - selA = I_instr[7:5]
  - selB = I_instr[4:2]
  - imm = I_instr[7:0]
- Timing relative to the ALU: decode outputs are stable a full cycle before O_en_alu asserts. The ALU samples at the negedge inside the ALU state.
- regDwe = 1 for opcodes 0-5 and 8-11 (Add, Sub, OR, AND, XOR, NOT, Load, Cmp, SHL, SHR).
- regDwe = 0 for opcodes 12 and 13 (JMPA, JMPR).
- Opcodes 6, 7, 14 and 15:
  - O_illegal = 1 and regDwe = 0; the fields are still latched.
  - The sequencer does not halt. O_illegal holds until the next DECODE.
- regDwe is a per-instruction qualifier. Register-file writes happen only when O_regDwe & O_en_wb.

Decomposition:
- Shared package (risc_pkg): opcode localparams (Add=0 … JMPR=13), state encodings, instruction field bit positions, INSTR_W and RSEL_W. The existing ALU uses the same opcode constants.
- One natural sub-module: ctrl_seq, holding the state register, I_stall handling and one-hot enable decode. Instruction field latching and the regDwe/illegal decode stay in decode_ctrl.

Test Plan:
- Reset then release, I_stall=0 -> O_state sequence 0,1,2,3,4,0 across six posedges; exactly one O_en_* high each cycle; all decode outputs 0 until the first DECODE.
- I_instr=16'h094C in DECODE -> O_aluop=5'b00001, O_selD=1, O_selA=2, O_selB=3, O_imm=8'h4C, O_regDwe=1, O_illegal=0; values held through WB.
- I_instr=16'h8BAB (Load high) -> O_aluop=5'b10001, O_selD=3, O_imm=8'hAB, O_regDwe=1. Then I_instr=16'hC012 (JMPA) -> O_aluop=5'b11000, O_regDwe=0.
- I_instr=16'h6000 (opcode 6) -> O_illegal=1, O_regDwe=0, sequencer still reaches WB then FETCH. Next instruction 16'h094C clears O_illegal at its DECODE.
- I_stall=1 for 3 cycles in FETCH -> O_en_fetch high 3 cycles, O_state=0. After I_stall=0, DECODE on the next edge; a stall asserted during ALU has no effect.
- I_rstn=0 for one cycle while O_state=3 (ALU) -> next state 0, O_aluop=0, O_regDwe=0, no O_en_wb pulse for that instruction.
